intr_req_ctrl: RTL
==================

Name: intr_req_ctrl

Overview:
- Initiator side of the fetch-stage interrupt handshake.
- Synchronises the external interrupt pin, detects requests and latches them as pending.
- Presents `intr` to the fetch-stage control unit only at a safe fetch boundary, then holds it until the fetch unit acknowledges with `int_clr`.
- Masks further requests while the handler runs, until RTI retires.

Parameters:
- SYNC_STAGES, 2, number of flops in the `irq_in` synchroniser (minimum 2).
- EDGE_MODE, 1, 1 = rising-edge triggered request; 0 = level triggered (pending while the synchronised pin is high).
- ACK_TIMEOUT, 15, cycles `intr` may stay asserted without `int_clr` before `ack_err` sets (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- irq_in  in  1  external interrupt pin, asynchronous to clk
- stall_in  in  1  pipeline stall; no new `intr` is raised while high
- fetch_busy  in  1  fetch CU mid-instruction (second byte of a two-byte fetch, or RET/RTI wait sequence)
- int_clr  in  1  acknowledge from the fetch CU; handler entry has started
- rti_retire  in  1  one-cycle pulse when RTI completes
- intr  out  1  interrupt request to the fetch CU (registered)
- in_isr  out  1  handler active; requests are masked
- pending  out  1  request latched, not yet presented
- ack_err  out  1  sticky: timeout waiting for `int_clr`

Behaviour:
- Reset (async, active-low):
  - All outputs 0; state S_IDLE.
  - Synchroniser flops and edge-detect history cleared to 0.
  - The timeout counter is cleared to 0.
  - Reset mid-handshake abandons it with no residue.
- Synchroniser:
  - `irq_in` passes through SYNC_STAGES flops, giving `irq_s`.
  - EDGE_MODE=1: req_evt = `irq_s` & ~`irq_s_d`.
  - EDGE_MODE=0: req_evt = `irq_s`.
  - Minimum latency from a pin edge to `pending`=1 is SYNC_STAGES+1 cycles.
- States (registered, one-hot or binary):
  - S_IDLE: on req_evt go to S_PEND, with `pending`=1 next cycle.
  - S_PEND:
    - When `stall_in`=0 and `fetch_busy`=0, go to S_REQ.
    - `intr`=1 and `pending`=0 from the next cycle.
    - Otherwise wait indefinitely.
  - S_REQ:
    - `intr` held at 1.
    - When `int_clr` is sampled at 1 on a rising edge, go to S_ISR; `intr`=0 and `in_isr`=1 from the next cycle.
    - Timeout counter increments each cycle in S_REQ. On reaching ACK_TIMEOUT, `ack_err` is set (sticky until reset) and `intr` stays asserted.
  - S_ISR:
    - req_evt is ignored (dropped).
    - On `rti_retire`=1, go to S_IDLE with `in_isr`=0 next cycle.
- Simultaneous events:
  - `rti_retire` together with req_evt in S_ISR: the event is dropped. In EDGE_MODE=0 a still-high pin re-triggers from S_IDLE on the next cycle.
  - `int_clr` in any state other than S_REQ: ignored.
  - `rti_retire` outside S_ISR: ignored.
  - req_evt in S_PEND or S_REQ: merged into the existing request (no double count).
- `intr` never rises in a cycle where `stall_in` or `fetch_busy` was high at the preceding edge.
- Timeout counter:
  - 8-bit, saturating.
  - Cleared on entry to S_REQ.

Optional Feature:
- Macro INTR_DROP_CNT_EN.
- Defined:
  - Adds output `drop_cnt` [7:0].
  - Saturating count of req_evt occurrences discarded in S_ISR, or merged in S_PEND/S_REQ.
  - Reset to 0.
  - A level-mode held pin counts once per entry into the discard condition, not per cycle.
- Not defined: no port, no counter logic.

Test Plan:
- Basic entry: EDGE_MODE=1, SYNC_STAGES=2, `irq_in` 0→1 at cycle 10, `stall_in`=`fetch_busy`=0 → `pending`=1 at cycle 13, `intr`=1 at 14; `int_clr`=1 at 16 → `intr`=0 and `in_isr`=1 at 17.
- Safe-point hold: request pending with `fetch_busy`=1 for 5 cycles then `stall_in`=1 for 3 → `intr` stays 0 throughout and rises 1 cycle after both are low.
- Masking: second `irq_in` edge while `in_isr`=1 → no new `pending`; `rti_retire` pulse → `in_isr`=0 next cycle, state S_IDLE; with INTR_DROP_CNT_EN, `drop_cnt`=1.
- Timeout: `intr` asserted, `int_clr` held 0 → `ack_err`=1 after 15 cycles, `intr` still 1; a later `int_clr` completes entry normally and `ack_err` stays 1.
- Level mode: EDGE_MODE=0, pin held high through the handler → after `rti_retire`, a new `pending`=1 the following cycle.
- Async reset asserted while in S_REQ → `intr`, `pending`, `in_isr`, `ack_err` all 0 immediately; after release, no spurious request without a new pin event.

Source files
------------

// File: rtl/intr_req_ctrl_if.sv
// Fetch-stage interrupt handshake bundle.
// master: the interrupt request controller.
// slave:  the fetch-stage control unit.
interface intr_req_ctrl_if;
    logic stall_in;
    logic fetch_busy;
    logic int_clr;
    logic rti_retire;
    logic intr;
    logic in_isr;
    logic pending;
    logic ack_err;

    modport master (
        input  stall_in,
        input  fetch_busy,
        input  int_clr,
        input  rti_retire,
        output intr,
        output in_isr,
        output pending,
        output ack_err
    );

    modport slave (
        output stall_in,
        output fetch_busy,
        output int_clr,
        output rti_retire,
        input  intr,
        input  in_isr,
        input  pending,
        input  ack_err
    );
endinterface

// File: rtl/intr_req_ctrl.sv
// Initiator side of the fetch-stage interrupt handshake.
// Synchronises irq_in, latches a request as pending, raises intr only at a safe
// fetch boundary, holds it until int_clr, then masks requests until RTI retires.
// Optional build macro INTR_DROP_CNT_EN adds the drop_cnt output counting
// discarded or merged request events.
module intr_req_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            irq_in,
    intr_req_ctrl_if.master bus
`ifdef INTR_DROP_CNT_EN
    ,
    output logic [7:0]      drop_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_REQ  = 2'd2,
        S_ISR  = 2'd3
    } state_t;

    localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   irq_hist_q, irq_hist_d;
    logic [7:0]             tmo_cnt_q, tmo_cnt_d;
    logic                   intr_q, intr_d;
    logic                   pending_q, pending_d;
    logic                   in_isr_q, in_isr_d;
    logic                   ack_err_q, ack_err_d;
    logic                   irq_s;
    logic                   req_evt;
    logic [7:0]             tmo_inc;

    assign irq_s   = sync_q[SYNC_STAGES-1];
    assign req_evt = EDGE_MODE ? (irq_s & ~irq_hist_q) : irq_s;

    // Shift the pin through the synchroniser and remember the last synchronised value.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], irq_in};
        irq_hist_d = irq_s;
    end

    // Handshake sequencing: idle -> pending -> request -> handler -> idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_evt) state_d = S_PEND;
            S_PEND: if (!bus.stall_in && !bus.fetch_busy) state_d = S_REQ;
            S_REQ:  if (bus.int_clr) state_d = S_ISR;
            S_ISR:  if (bus.rti_retire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Acknowledge timeout: count cycles spent in S_REQ and latch a sticky error.
    always_comb begin
        tmo_inc   = (tmo_cnt_q == 8'hFF) ? tmo_cnt_q : tmo_cnt_q + 8'd1;
        tmo_cnt_d = tmo_cnt_q;
        ack_err_d = ack_err_q;
        if (state_q != S_REQ && state_d == S_REQ) begin
            tmo_cnt_d = 8'd0;
        end else if (state_q == S_REQ) begin
            tmo_cnt_d = tmo_inc;
            if (!bus.int_clr && tmo_inc == ACK_LIMIT) begin
                ack_err_d = 1'b1;
            end
        end
    end

    // Outputs are registered decodes of the next state so they never glitch.
    always_comb begin
        intr_d    = (state_d == S_REQ);
        pending_d = (state_d == S_PEND);
        in_isr_d  = (state_d == S_ISR);
    end

    // State, synchroniser and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            sync_q     <= '0;
            irq_hist_q <= 1'b0;
            tmo_cnt_q  <= 8'd0;
            intr_q     <= 1'b0;
            pending_q  <= 1'b0;
            in_isr_q   <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            irq_hist_q <= irq_hist_d;
            tmo_cnt_q  <= tmo_cnt_d;
            intr_q     <= intr_d;
            pending_q  <= pending_d;
            in_isr_q   <= in_isr_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign bus.intr    = intr_q;
    assign bus.pending = pending_q;
    assign bus.in_isr  = in_isr_q;
    assign bus.ack_err = ack_err_q;

`ifdef INTR_DROP_CNT_EN
    logic       drop_cond;
    logic       drop_cond_q, drop_cond_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    assign drop_cond = req_evt & (state_q != S_IDLE);

    // Count each entry into the discard/merge condition once, saturating at 255.
    always_comb begin
        drop_cond_d = drop_cond;
        drop_cnt_d  = drop_cnt_q;
        if (drop_cond && !drop_cond_q && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Drop counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cond_q <= 1'b0;
            drop_cnt_q  <= 8'd0;
        end else begin
            drop_cond_q <= drop_cond_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    // Drop counting is not built in this configuration.
`endif

endmodule
